// File: rtl/rx_fifo_reg_pkg.sv
// Shared definitions for the receive FIFO register block: IIR codes, register
// bit positions and the FIFO trigger-level decode.
package rx_fifo_reg_pkg;

  // Interrupt identification codes, in the low nibble of IIR.
  typedef enum logic [3:0] {
    IirNone = 4'b0001,
    IirRls  = 4'b0110,
    IirRda  = 4'b0100,
    IirCto  = 4'b1100
  } iir_code_e;

  // LSR bit positions
  localparam int unsigned LsrDr     = 0;
  localparam int unsigned LsrOe     = 1;
  // FCR bit positions
  localparam int unsigned FcrEn     = 0;
  localparam int unsigned FcrClr    = 1;
  localparam int unsigned FcrTrigLo = 6;
  // IER bit positions
  localparam int unsigned IerRda    = 0;
  localparam int unsigned IerRls    = 2;

  // Receive trigger level; holding-register mode always triggers on one character.
  function automatic int unsigned trigger_level(input logic [1:0] sel,
                                                input logic fifo_en,
                                                input int unsigned depth);
    int unsigned lvl;
    lvl = 1;
    if (fifo_en) begin
      unique case (sel)
        2'b00:   lvl = 1;
        2'b01:   lvl = depth / 4;
        2'b10:   lvl = depth / 2;
        default: lvl = depth - 2;
      endcase
    end
    return lvl;
  endfunction

endpackage

// File: rtl/rx_fifo_reg_sync_fifo.sv
// Synchronous FIFO storage: wrapping pointers plus an explicit occupancy count,
// so every data value (including zero) is legal. Pops past empty and pushes
// past full (without a same-cycle pop) are ignored.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem[rptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state; flush wins over push and pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PtrW'(1);
      if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since the count masks stale entries.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rx_fifo_reg.sv
// UART receive side: RX FIFO / holding register with LSR data-ready and
// overrun, character timeout and IIR priority encoding.
module rx_fifo_reg
  import rx_fifo_reg_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TO_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic                   rd,
  input  logic                   lsr_rd,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [7:0]             fcr,
  input  logic [7:0]             ier,
  output logic [DATA_W-1:0]      data_out,
  output logic [7:0]             iir,
  output logic [7:0]             lsr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned ToW  = $clog2(TO_CYCLES + 1);

  logic              fifo_en, fifo_en_q;
  logic              flush, push, pop, overrun, eff_full;
  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count, count_next;
  logic [DATA_W-1:0] fifo_rdata, data_out_q;
  logic              ovr_q, ovr_d, dr_q;
  logic [ToW-1:0]    to_q, to_d;
  logic              to_pending, at_trigger;
  int unsigned       trig;
  iir_code_e         iir_code;
  logic [7:0]        iir_q, iir_d;
  logic              unused_bits;

  assign unused_bits = ^{fcr[5:2], ier[7:3], ier[1]};

  assign fifo_en = fcr[FcrEn];
  // Toggling FIFO mode reinterprets the storage, so it clears like an explicit flush.
  assign flush   = fcr[FcrClr] | (fifo_en != fifo_en_q);
  // Holding-register mode is a FIFO of effective depth one.
  assign eff_full = fifo_en ? fifo_full : (fifo_count != '0);
  assign pop      = rd & ~fifo_empty & ~flush;
  assign push     = wr & ~flush & (~eff_full | pop);
  assign overrun  = wr & ~flush & eff_full & ~pop;
  assign count_next = flush ? '0 : (fifo_count + CntW'(push) - CntW'(pop));

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sync_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (data_in),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Overrun sticky bit and timeout counter next-state.
  always_comb begin
    ovr_d = ovr_q;
    if (overrun)     ovr_d = 1'b1;
    else if (lsr_rd) ovr_d = 1'b0;

    to_d = to_q;
    if (flush || wr || rd || fifo_count == '0) to_d = '0;
    else if (to_q != ToW'(TO_CYCLES))          to_d = to_q + ToW'(1);
  end

  assign trig       = trigger_level(fcr[FcrTrigLo +: 2], fifo_en, DEPTH);
  assign at_trigger = (32'(fifo_count) >= trig);
  assign to_pending = fifo_en & (to_q == ToW'(TO_CYCLES)) & (fifo_count != '0);

  // Interrupt priority: line status, then data available, then timeout.
  always_comb begin
    iir_code = IirNone;
    if (ovr_q && ier[IerRls])           iir_code = IirRls;
    else if (at_trigger && ier[IerRda]) iir_code = IirRda;
    else if (to_pending && ier[IerRda]) iir_code = IirCto;
    iir_d = {fifo_en ? 2'b11 : 2'b00, 2'b00, iir_code};
  end

  // Status, data and interrupt registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_en_q  <= 1'b0;
      data_out_q <= '0;
      ovr_q      <= 1'b0;
      dr_q       <= 1'b0;
      to_q       <= '0;
      iir_q      <= 8'h01;
    end else begin
      fifo_en_q  <= fifo_en;
      if (pop) data_out_q <= fifo_rdata;
      ovr_q      <= ovr_d;
      dr_q       <= (count_next != '0);
      to_q       <= to_d;
      iir_q      <= iir_d;
    end
  end

  assign data_out = data_out_q;
  assign count    = fifo_count;
  assign iir      = iir_q;
  assign lsr      = {6'b0, ovr_q, dr_q};

endmodule

// File: tb/tb_rx_fifo_reg.sv
// Self-checking bench for rx_fifo_reg with a data scoreboard queue.
module tb_rx_fifo_reg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset, wr, rd, lsr_rd;
  logic [DATA_W-1:0] data_in;
  logic [7:0]        fcr, ier;
  logic [DATA_W-1:0] data_out;
  logic [7:0]        iir, lsr;
  logic [4:0]        count;

  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] exp_last;
  logic              prev_en;
  int                errors = 0;
  int                checks = 0;

  always #5 clk = ~clk;

  rx_fifo_reg #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .TO_CYCLES (64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .rd       (rd),
    .lsr_rd   (lsr_rd),
    .data_in  (data_in),
    .fcr      (fcr),
    .ier      (ier),
    .data_out (data_out),
    .iir      (iir),
    .lsr      (lsr),
    .count    (count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fcr(input logic [7:0] v);
    if (v[1] || (v[0] != prev_en)) sb_q.delete();
    prev_en = v[0];
    fcr = v;
    tick();
  endtask

  function automatic int eff_depth();
    return fcr[0] ? DEPTH : 1;
  endfunction

  task automatic do_wr(input logic [DATA_W-1:0] d);
    if (sb_q.size() < eff_depth()) sb_q.push_back(d);
    wr = 1'b1; data_in = d;
    tick();
    wr = 1'b0;
    check_eq("wr_count", 32'(count), 32'(sb_q.size()));
  endtask

  task automatic do_rd();
    if (sb_q.size() > 0) exp_last = sb_q.pop_front();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check_eq("rd_data", 32'(data_out), 32'(exp_last));
    check_eq("rd_count", 32'(count), 32'(sb_q.size()));
  endtask

  // Push and pop in one cycle: the pop only happens if data was present.
  task automatic do_wrrd(input logic [DATA_W-1:0] d);
    if (sb_q.size() > 0) begin
      exp_last = sb_q.pop_front();
      sb_q.push_back(d);
    end else begin
      sb_q.push_back(d);
    end
    wr = 1'b1; rd = 1'b1; data_in = d;
    tick();
    wr = 1'b0; rd = 1'b0;
    check_eq("wrrd_data", 32'(data_out), 32'(exp_last));
    check_eq("wrrd_count", 32'(count), 32'(sb_q.size()));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb_q.delete();
    exp_last = '0;
    prev_en  = 1'b0;
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_data", 32'(data_out), 0);
    check_eq("rst_lsr", 32'(lsr), 32'h00);
    check_eq("rst_iir", 32'(iir), 32'h01);
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; lsr_rd = 1'b0;
    data_in = '0; fcr = 8'h00; ier = 8'h00;
    exp_last = '0; prev_en = 1'b0;
    do_reset();

    // Ordered data including zero; data-ready falls after the last read.
    set_fcr(8'h01);
    do_wr(8'h00); do_wr(8'h5A); do_wr(8'hFF);
    check_eq("dr_set", 32'(lsr), 32'h01);
    do_rd(); do_rd();
    check_eq("dr_held", 32'(lsr), 32'h01);
    do_rd();
    check_eq("dr_clr", 32'(lsr), 32'h00);
    do_rd();  // empty read: data_out and count unchanged

    // Overflow, line-status interrupt and overrun clear.
    ier = 8'h04;
    for (int i = 0; i < 17; i++) do_wr(8'(8'h10 + i));
    check_eq("ovr_count", 32'(count), 16);
    check_eq("ovr_lsr", 32'(lsr), 32'h03);
    tick();
    check_eq("rls_iir", 32'(iir), 32'hC6);
    lsr_rd = 1'b1; tick(); lsr_rd = 1'b0;
    check_eq("lsr_rd_clr", 32'(lsr), 32'h01);
    lsr_rd = 1'b1; do_wr(8'h77); lsr_rd = 1'b0;
    check_eq("ovr_wins", 32'(lsr), 32'h03);
    lsr_rd = 1'b1; tick(); lsr_rd = 1'b0;
    do_wrrd(8'hA5);
    check_eq("full_wrrd_no_ovr", 32'(lsr), 32'h01);
    for (int i = 0; i < 16; i++) do_rd();
    check_eq("drained", 32'(lsr), 32'h00);

    // Trigger level 14.
    ier = 8'h01;
    set_fcr(8'hC1);
    for (int i = 0; i < 13; i++) do_wr(8'(8'h40 + i));
    tick();
    check_eq("trig13_iir", 32'(iir), 32'hC1);
    do_wr(8'h4D);
    tick();
    check_eq("trig14_iir", 32'(iir), 32'hC4);
    set_fcr(8'hC3);
    set_fcr(8'hC1);
    check_eq("clr_count", 32'(count), 0);

    // Data-available at trigger 1, then character timeout at trigger 4.
    set_fcr(8'h01);
    do_wr(8'h33);
    tick();
    check_eq("rda_iir", 32'(iir), 32'hC4);
    do_rd();
    tick();
    check_eq("rda_clr_iir", 32'(iir), 32'hC1);
    set_fcr(8'h41);
    do_wr(8'h44);
    for (int i = 0; i < 60; i++) tick();
    check_eq("pre_to_iir", 32'(iir), 32'hC1);
    for (int i = 0; i < 5; i++) tick();
    check_eq("to_iir", 32'(iir), 32'hCC);
    do_rd();
    tick();
    check_eq("to_clr_iir", 32'(iir), 32'hC1);

    // Holding-register mode.
    set_fcr(8'h00);
    do_wr(8'h12); do_wr(8'h34);
    do_rd();
    check_eq("hr_lsr", 32'(lsr), 32'h02);
    tick();
    check_eq("hr_iir", 32'(iir), 32'h01);
    lsr_rd = 1'b1; tick(); lsr_rd = 1'b0;
    do_wr(8'h56);
    do_wrrd(8'h78);
    check_eq("hr_wrrd_lsr", 32'(lsr), 32'h01);
    do_rd();
    do_wrrd(8'h9A);  // empty: push only, data_out keeps 0x78
    check_eq("empty_wrrd_lsr", 32'(lsr), 32'h01);

    // Reset mid-operation.
    set_fcr(8'h01);
    do_wr(8'hC3); do_wr(8'h3C);
    ier = 8'h05;
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_fifo_reg.md
RX_FIFO_REG -- requirements
Module: rx_fifo_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 8: received character width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, at least 4.
REQ-003 SHALL have parameter TO_CYCLES, default 64: idle clk cycles before character timeout.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port wr, input, 1: one-cycle push strobe from the receiver shifter.
REQ-007 SHALL have port rd, input, 1: one-cycle processor read of the receive buffer.
REQ-008 SHALL have port lsr_rd, input, 1: one-cycle processor read of the LSR.
REQ-009 SHALL have port data_in, input, DATA_W: character to push.
REQ-010 SHALL have port fcr, input, 8: FIFO control.
  - [0] FIFO enable.
  - [1] RX clear.
  - [7:6] trigger select.
REQ-011 SHALL have port ier, input, 8: interrupt enables.
  - [0] RX data and timeout.
  - [2] line status.
REQ-012 SHALL have port data_out, output, DATA_W: last popped character.
REQ-013 SHALL have port iir, output, 8: interrupt identification.
REQ-014 SHALL have port lsr, output, 8: line status.
  - [0] data ready.
  - [1] overrun.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy.

Function
REQ-016 Effective depth SHALL be DEPTH when fcr[0]=1 and 1 when fcr[0]=0 (holding-register mode).
REQ-017 Occupancy SHALL be tracked with a valid count, so 0x00 is legal data.
REQ-018 wr with occupancy below effective depth SHALL store data_in; count SHALL increment next cycle.
REQ-019 wr when full SHALL discard data_in and set lsr[1]; FIFO contents SHALL be unchanged.
REQ-020 rd with count>0 SHALL load data_out with the oldest entry and pop it, one-cycle latency.
REQ-021 rd with count=0 SHALL leave data_out and count unchanged.
REQ-022 Simultaneous wr and rd when full SHALL pop and push in the same cycle, with no overrun and count unchanged.
REQ-023 Simultaneous wr and rd when empty SHALL store the push only; data_out SHALL be unchanged.
REQ-024 lsr_rd SHALL clear lsr[1] next cycle; an overrun in the same cycle as lsr_rd SHALL win (lsr[1] stays 1).
REQ-025 lsr[0] SHALL equal (count!=0), registered; lsr[7:2] SHALL be 0.
REQ-026 fcr[1]=1, or any change of fcr[0], SHALL empty the FIFO and clear the timeout counter in that cycle, overriding wr and rd; lsr[1] SHALL be kept.
REQ-027 Trigger level from fcr[7:6] SHALL be 00->1, 01->DEPTH/4, 10->DEPTH/2, 11->DEPTH-2; in non-FIFO mode the trigger SHALL be 1.
REQ-028 Timeout counter SHALL reset on wr, rd or count=0, SHALL otherwise increment, and SHALL saturate at TO_CYCLES.
REQ-029 Timeout SHALL be pending when counter=TO_CYCLES and count>0, in FIFO mode only.
REQ-030 iir[3:0] SHALL be selected by priority, registered:
  - 0110 when lsr[1] and ier[2].
  - else 0100 when count>=trigger and ier[0].
  - else 1100 when timeout pending and ier[0].
  - else 0001.
REQ-031 iir[7:6] SHALL be 11 in FIFO mode, else 00; iir[5:4] SHALL be 0.

Reset
REQ-032 On reset: count=0, FIFO empty, data_out=0, lsr=0x00, iir=0x01, timeout counter=0.
REQ-033 Reset mid-operation SHALL discard all entries and pending interrupts on the next edge.

Structure
REQ-034 A shared package SHALL hold IIR codes (NONE, RLS, RDA, CTO), LSR/FCR/IER bit indices and the trigger-decode function.
REQ-035 Storage SHALL be one sub-module, sync_fifo (DATA_W, DEPTH), providing push, pop, flush, full, empty and count.
REQ-036 The FIFO SHALL use wrapping pointers of $clog2(DEPTH) bits plus a separate count, with no reads past empty.

Verification
REQ-037 fcr=0x01: push 0x00, 0x5A, 0xFF, then 3 rd -> data_out 0x00, 0x5A, 0xFF; lsr[0] falls after the third read.
REQ-038 fcr=0x01, DEPTH=16: push 17 -> count=16, lsr[1]=1, iir=0xC6 with ier=0x04; lsr_rd -> lsr[1]=0.
REQ-039 fcr=0xC1, ier=0x01: push 13 -> iir=0xC1; push 14th -> iir=0xC4.
REQ-040 fcr=0x01, ier=0x01, push 1 (trigger 1) then read it; push 1 with fcr=0x41, idle 64 cycles -> iir=0xCC; rd -> iir=0xC1.
REQ-041 fcr=0x00: push 0x12, push 0x34 -> data_out after rd is 0x12 and lsr[1]=1; full FIFO with wr+rd together -> no overrun, count unchanged.
